seqdet_prog: RTL and testbench

Programmable serial pattern detector for the 1-bit qualified input stream (`din`/`din_vld`). It is the parametrised successor of the fixed-pattern detector. Pattern, length and overlap mode are loaded at run time, and a saturating match counter is kept. It sits on the same serial input path and drives a registered one-cycle `result` pulse per detected pattern.

---
 rtl/seqdet_pkg.sv | 16 +
 rtl/seqdet_sat_cnt.sv | 26 ++
 rtl/seqdet_prog.sv | 103 ++++++++++
 tb/tb_seqdet_prog.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seqdet_pkg;

    typedef enum logic {
        UNCFG = 1'b0,
        RUN   = 1'b1
    } seqdet_state_t;

    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    localparam seqdet_state_t ST_RST  = UNCFG;
    localparam logic          BIT_RST = 1'b0;

endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating up-counter; clear wins over increment.
module seqdet_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seqdet_prog.sv
// Programmable serial pattern detector: run-time pattern/length/overlap,
// registered match pulse and saturating match counter.
module seqdet_prog
    import seqdet_pkg::*;
#(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 16,
    localparam int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_vld,
    input  logic             din,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             result,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err,
    output logic             armed
);

    seqdet_state_t    r_state;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic             r_result;
    logic             r_cfg_err;
    logic             r_armed;

    logic             w_len_ok;
    logic             w_acc;
    logic [PAT_W-1:0] w_hist_n;
    logic [LEN_W-1:0] w_fill_n;
    logic [PAT_W-1:0] w_mask;
    logic             w_match;

    assign w_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    assign w_acc    = (r_state == RUN) && din_vld && !cfg_load;
    assign w_hist_n = {r_hist[PAT_W-2:0], din};
    assign w_fill_n = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + 1'b1;

    // Thermometer mask selects the low r_len bits of the history
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match = w_acc && (w_fill_n >= r_len)
                   && (((w_hist_n ^ r_pat) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RST;
            r_pat     <= '0;
            r_len     <= '0;
            r_ovl     <= BIT_RST;
            r_hist    <= '0;
            r_fill    <= '0;
            r_result  <= BIT_RST;
            r_cfg_err <= BIT_RST;
            r_armed   <= BIT_RST;
        end else if (cfg_load) begin
            r_pat     <= cfg_pattern;
            r_len     <= cfg_len;
            r_ovl     <= cfg_overlap;
            r_hist    <= '0;
            r_fill    <= '0;
            r_result  <= 1'b0;
            r_cfg_err <= !w_len_ok;
            r_armed   <= w_len_ok;
            r_state   <= w_len_ok ? RUN : UNCFG;
        end else begin
            r_cfg_err <= 1'b0;
            r_result  <= w_match;
            if (w_acc) begin
                r_hist <= w_hist_n;
                r_fill <= (w_match && !r_ovl) ? '0 : w_fill_n;
            end
        end
    end

    seqdet_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (cnt_clr),
        .i_inc (w_match),
        .o_cnt (match_cnt)
    );

    assign result  = r_result;
    assign cfg_err = r_cfg_err;
    assign armed   = r_armed;

endmodule

// File: tb/tb_seqdet_prog.sv
// Scoreboard bench for seqdet_prog with a queue-based reference model.
module tb_seqdet_prog;

    localparam int PAT_W   = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             din_vld;
    logic             din;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             result;
    logic [CNT_W-1:0] match_cnt;
    logic             cfg_err;
    logic             armed;

    seqdet_prog #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din_vld     (din_vld),
        .din         (din),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .result      (result),
        .match_cnt   (match_cnt),
        .cfg_err     (cfg_err),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit res;
        int cnt;
        bit err;
        bit arm;
    } exp_t;

    exp_t q_exp[$];
    int   n_run;
    int   n_fail;
    int   n_puls;

    bit              m_run;
    int              m_len;
    bit [PAT_W-1:0]  m_pat;
    bit              m_ovl;
    int              m_cnt;
    bit              m_bits[$];

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit ld, input bit [PAT_W-1:0] pat,
                        input int len, input bit ovl, input bit v,
                        input bit d, input bit clr);
        exp_t e;
        bit   hit;
        int   n;
        rst         = r;
        cfg_load    = ld;
        cfg_pattern = ld ? pat : PAT_W'($urandom);
        cfg_len     = ld ? LEN_W'(len) : LEN_W'($urandom);
        cfg_overlap = ld ? ovl : 1'($urandom);
        din_vld     = v;
        din         = d;
        cnt_clr     = clr;
        e   = '{res: 1'b0, cnt: m_cnt, err: 1'b0, arm: m_run};
        hit = 1'b0;
        if (r) begin
            m_run = 0; m_len = 0; m_pat = '0; m_ovl = 0; m_cnt = 0;
            m_bits.delete();
            e = '{res: 1'b0, cnt: 0, err: 1'b0, arm: 1'b0};
        end else begin
            if (ld) begin
                m_run = (len >= 1) && (len <= PAT_W);
                m_len = len; m_pat = pat; m_ovl = ovl;
                m_bits.delete();
                e.err = !m_run;
                e.arm = m_run;
            end else if (m_run && v) begin
                m_bits.push_back(d);
                if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                n   = m_bits.size();
                hit = (n >= m_len);
                for (int k = 0; k < m_len && hit; k++) begin
                    if (m_bits[n-1-k] != m_pat[k]) hit = 1'b0;
                end
                if (hit && !m_ovl) m_bits.delete();
            end
            if (clr) m_cnt = 0;
            else if (hit && m_cnt < CNT_MAX) m_cnt++;
            e.res = hit;
            e.cnt = m_cnt;
        end
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        check("result", int'(result), int'(e.res));
        check("match_cnt", int'(match_cnt), e.cnt);
        check("cfg_err", int'(cfg_err), int'(e.err));
        check("armed", int'(armed), int'(e.arm));
        if (result) n_puls++;
    endtask

    task automatic load(input bit [PAT_W-1:0] pat, input int len, input bit ovl);
        step(0, 1, pat, len, ovl, 0, 0, 0);
    endtask

    task automatic feed(input bit d);
        step(0, 0, '0, 0, 0, 1, d, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear();
        step(0, 0, '0, 0, 0, 0, 0, 1);
    endtask

    task automatic feed_word(input bit [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) feed(w[i]);
    endtask

    initial begin
        bit [15:0] s;
        n_run = 0; n_fail = 0; n_puls = 0;
        m_cnt = 0; m_run = 0; m_len = 0; m_pat = '0; m_ovl = 0;
        rst = 1; din_vld = 0; din = 0; cfg_load = 0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cnt_clr = 0;

        step(1, 0, '0, 0, 0, 1, 1, 0);
        step(1, 0, '0, 0, 0, 0, 0, 0);
        feed_word(16'b1011, 4);
        check("uncfg_pulses", n_puls, 0);

        // overlapping 1011 on 1011011
        clear();
        load(8'b1011, 4, 1'b1);
        n_puls = 0;
        s = 16'b1011011;
        feed_word(s, 7);
        check("ovl_pulses", n_puls, 2);
        check("ovl_cnt", int'(match_cnt), 2);

        // non-overlapping on same stream
        clear();
        load(8'b1011, 4, 1'b0);
        n_puls = 0;
        feed_word(s, 7);
        check("novl_pulses", n_puls, 1);
        check("novl_cnt", int'(match_cnt), 1);

        // gaps are transparent
        load(8'b111000, 6, 1'b1);
        n_puls = 0;
        s = 16'b111000;
        for (int i = 5; i >= 0; i--) begin
            feed(s[i]);
            if (i != 0) idle(3);
        end
        check("gap_pulses", n_puls, 1);

        // illegal lengths
        load(8'b1, 0, 1'b1);
        n_puls = 0;
        feed_word(16'hFFFF, 4);
        load(8'b1, 9, 1'b1);
        feed_word(16'hFFFF, 4);
        check("bad_pulses", n_puls, 0);
        check("bad_armed", int'(armed), 0);
        load(8'b1, 1, 1'b1);
        check("good_armed", int'(armed), 1);

        // saturation, coincident clear, dropped bit on load
        clear();
        step(0, 1, 8'b1, 1, 1'b1, 1, 1, 0);
        n_puls = 0;
        feed_word(16'h1F, 5);
        check("sat_pulses", n_puls, 5);
        check("sat_cnt", int'(match_cnt), CNT_MAX);
        step(0, 0, '0, 0, 0, 1, 1, 1);
        check("clr_res", int'(result), 1);
        check("clr_cnt", int'(match_cnt), 0);

        // reload mid-pattern discards history
        load(8'b1011, 4, 1'b1);
        feed_word(16'b101, 3);
        load(8'b1011, 4, 1'b1);
        n_puls = 0;
        feed_word(16'b1011, 4);
        check("reload_pulses", n_puls, 1);

        // reset before last bit
        load(8'b1011, 4, 1'b1);
        n_puls = 0;
        feed_word(16'b101, 3);
        step(1, 0, '0, 0, 0, 0, 0, 0);
        feed(1'b1);
        check("rst_pulses", n_puls, 0);
        check("rst_armed", int'(armed), 0);

        // reset coincident with completing bit suppresses pulse
        load(8'b1011, 4, 1'b1);
        feed_word(16'b101, 3);
        step(1, 0, '0, 0, 0, 1, 1, 0);
        check("rst_hit_res", int'(result), 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
